alu_mc: RTL and testbench

Parametrised, handshaked successor of the datapath ALU. It registers every result behind a valid/ready output stage. It adds an iterative multiply/divide unit (MDU) that takes WIDTH cycles per operation. It sits in the execute stage between operand issue and writeback, and it stalls issue through `in_ready` while a long operation is in flight.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu_mdu_iter.sv | 79 +++++++
 rtl/alu_mc.sv | 131 +++++++++++++
 tb/tb_alu_mc.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the handshaked ALU.
package alu_pkg;

    // Single-cycle ops: F[4]=0, F[3] inverts B, F[2:0] picks the result.
    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_SUB  = 5'b01100;
    localparam logic [4:0] OP_SLT  = 5'b01110;
    localparam logic [4:0] OP_SLL  = 5'b00111;
    localparam logic [4:0] OP_SRL  = 5'b00101;
    localparam logic [4:0] OP_SRA  = 5'b00011;
    localparam logic [4:0] OP_LUI  = 5'b00001;

    // Iterative ops: F[4]=1, F[3:2] ignored, F[1] = divide, F[0] = upper half.
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_MULH = 5'b10001;
    localparam logic [4:0] OP_DIVU = 5'b10010;
    localparam logic [4:0] OP_REMU = 5'b10011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } alu_state_t;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative unsigned multiply / restoring divide, one bit per cycle.
// A single 2*WIDTH register holds {hi, lo}: for multiply it is the
// product with the multiplier shifted out of the low half; for divide
// the upper half is the partial remainder and the lower half shifts the
// dividend out while the quotient bits shift in.
// lo/hi present the value after the current step, so the owner can
// capture the final result on the same edge that performs the last step.
module alu_mdu_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             done,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod_q;
    logic [2*WIDTH-1:0] prod_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               active_q;
    logic               div_q;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;

    // One step of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
                  + (prod_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        div_ge    = ~div_diff[WIDTH];
        if (div_q) begin
            prod_d = {(div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0]),
                      prod_q[WIDTH-2:0], div_ge};
        end else begin
            prod_d = {mul_sum, prod_q[WIDTH-1:1]};
        end
    end

    assign lo   = prod_d[WIDTH-1:0];
    assign hi   = prod_d[2*WIDTH-1:WIDTH];
    assign done = active_q && (cnt_q == '0);

    // Operand latch on start, then WIDTH steps counted down to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            prod_q   <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            div_q    <= 1'b0;
        end else if (start) begin
            prod_q   <= {{WIDTH{1'b0}}, (is_div ? A : B)};
            opnd_q   <= is_div ? B : A;
            cnt_q    <= CNT_W'(WIDTH - 1);
            active_q <= 1'b1;
            div_q    <= is_div;
        end else if (active_q) begin
            prod_q <= prod_d;
            if (cnt_q == '0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Handshaked execute-stage ALU: single-cycle ops plus an iterative MDU,
// with every result held in a valid/ready output register.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int IMM_W   = WIDTH / 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [4:0]         F,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [IMM_W-1:0]   imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   Y,
    output logic               Zero,
    output logic               busy,
    output alu_state_t         dbg_state_o
);

    // Handshake: an op transfers on an edge where in_valid && in_ready; a
    // result transfers on an edge where out_valid && out_ready. in_ready is
    // only high in IDLE with the output register free or being drained, so
    // a result can never be overwritten before it is taken.

    alu_state_t       state_q;
    logic             sel_hi_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] y_q;
    logic             zero_q;

    logic             accept;
    logic [WIDTH-1:0] b_out;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] alu_res;
    logic             wr_en;
    logic [WIDTH-1:0] wr_data;
    logic             mdu_done;
    logic [WIDTH-1:0] mdu_lo;
    logic [WIDTH-1:0] mdu_hi;

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    alu_mdu_iter #(.WIDTH(WIDTH)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && F[4]),
        .is_div (F[1]),
        .A      (A),
        .B      (B),
        .done   (mdu_done),
        .lo     (mdu_lo),
        .hi     (mdu_hi)
    );

    // Single-cycle result: adder/logic/shift selected by F[2:0].
    always_comb begin
        b_out = F[3] ? ~B : B;
        sum   = A + b_out + {{(WIDTH-1){1'b0}}, F[3]};
        unique case (F[2:0])
            3'b000:  alu_res = A & b_out;
            3'b010:  alu_res = A | b_out;
            3'b100:  alu_res = sum;
            3'b110:  alu_res = {{(WIDTH-1){1'b0}}, sum[WIDTH-1]};
            3'b111:  alu_res = B << shamt;
            3'b101:  alu_res = B >> shamt;
            3'b011:  alu_res = WIDTH'($signed(B) >>> shamt);
            default: alu_res = {imm, {IMM_W{1'b0}}};
        endcase
    end

    // Output-register write: a single-cycle op on accept, or the MDU on its last step.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = alu_res;
        if (state_q == IDLE) begin
            wr_en = accept && !F[4];
        end else if (mdu_done) begin
            wr_en   = 1'b1;
            wr_data = sel_hi_q ? mdu_hi : mdu_lo;
        end
    end

    // FSM and output register with valid/ready bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_hi_q    <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept && F[4]) begin
                        state_q  <= F[1] ? DIV : MUL;
                        sel_hi_q <= F[0];
                    end
                end
                MUL, DIV: begin
                    if (mdu_done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

            if (wr_en) begin
                y_q         <= wr_data;
                zero_q      <= (wr_data == '0);
                out_valid_q <= 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid   = out_valid_q;
    assign Y           = y_q;
    assign Zero        = zero_q;
    assign busy        = (state_q != IDLE);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// Bench for alu_mc: a 32-bit and an 8-bit instance, a scoreboard queue per
// instance filled on accept and drained when the DUT hands over a result.
module tb_alu_mc;
    import alu_pkg::*;

    localparam int W  = 32;
    localparam int W8 = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- 32-bit instance ----------------
    logic          in_valid, in_ready, out_valid, out_ready, zero, busy;
    logic [W-1:0]  a, b, y;
    logic [4:0]    f;
    logic [4:0]    shamt;
    logic [15:0]   imm;
    alu_state_t    dbg_state;

    alu_mc #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .F(f), .shamt(shamt), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .Y(y), .Zero(zero),
        .busy(busy), .dbg_state_o(dbg_state)
    );

    // ---------------- 8-bit instance ----------------
    logic          in_valid8, in_ready8, out_valid8, out_ready8, zero8, busy8;
    logic [W8-1:0] a8, b8, y8;
    logic [4:0]    f8;
    logic [2:0]    shamt8;
    logic [3:0]    imm8;
    alu_state_t    dbg_state8;

    alu_mc #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .A(a8), .B(b8), .F(f8), .shamt(shamt8), .imm(imm8),
        .out_valid(out_valid8), .out_ready(out_ready8), .Y(y8), .Zero(zero8),
        .busy(busy8), .dbg_state_o(dbg_state8)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [W-1:0]  exp_q[$];
    logic [W8-1:0] exp8_q[$];
    logic [W-1:0]  mon_e;
    logic [W8-1:0] mon_e8;

    // Inputs only change just after a rising edge, so values seen at the
    // falling edge are the ones the next rising edge will act on.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result32 got Y=%h, required no result", y);
            end else begin
                mon_e = exp_q.pop_front();
                if (y !== mon_e || zero !== (mon_e == '0)) begin
                    failures++;
                    $display("FAIL result32 got Y=%h Zero=%b, required Y=%h Zero=%b",
                             y, zero, mon_e, (mon_e == '0));
                end
            end
        end
        if (!rst && out_valid8 && out_ready8) begin
            checks++;
            if (exp8_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_result8 got Y=%h, required no result", y8);
            end else begin
                mon_e8 = exp8_q.pop_front();
                if (y8 !== mon_e8 || zero8 !== (mon_e8 == '0)) begin
                    failures++;
                    $display("FAIL result8 got Y=%h Zero=%b, required Y=%h Zero=%b",
                             y8, zero8, mon_e8, (mon_e8 == '0));
                end
            end
        end
    end

    // ---------------- reference model (32-bit) ----------------
    function automatic logic [W-1:0] model32(input logic [4:0] op, input logic [W-1:0] av,
                                             input logic [W-1:0] bv, input logic [4:0] sh,
                                             input logic [15:0] im);
        logic [2*W-1:0] p;
        logic [W-1:0]   bo, s, r;
        p  = {{W{1'b0}}, av} * {{W{1'b0}}, bv};
        bo = op[3] ? ~bv : bv;
        s  = av + bo + {31'b0, op[3]};
        if (op[4]) begin
            case (op[1:0])
                2'b00:   r = p[W-1:0];
                2'b01:   r = p[2*W-1:W];
                2'b10:   r = (bv == 0) ? '1 : av / bv;
                default: r = (bv == 0) ? av : av % bv;
            endcase
        end else begin
            case (op[2:0])
                3'b000:  r = av & bo;
                3'b010:  r = av | bo;
                3'b100:  r = s;
                3'b110:  r = {31'b0, s[W-1]};
                3'b111:  r = bv << sh;
                3'b101:  r = bv >> sh;
                3'b011:  r = W'($signed(bv) >>> sh);
                default: r = {im, 16'b0};
            endcase
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send32(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [4:0] sh, input logic [15:0] im, input logic [W-1:0] e);
        bit ok;
        f = op; a = av; b = bv; shamt = sh; imm = im; in_valid = 1'b1;
        #1;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (in_ready === 1'b1) ok = 1;
            else tick();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout32 got in_ready=%b, required 1 within 200 cycles", in_ready);
        end else begin
            exp_q.push_back(e);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send8(input logic [4:0] op, input logic [W8-1:0] av, input logic [W8-1:0] bv,
                         input logic [2:0] sh, input logic [3:0] im, input logic [W8-1:0] e);
        bit ok;
        f8 = op; a8 = av; b8 = bv; shamt8 = sh; imm8 = im; in_valid8 = 1'b1;
        #1;
        ok = 0;
        for (int k = 0; k < 200 && !ok; k++) begin
            if (in_ready8 === 1'b1) ok = 1;
            else tick();
        end
        if (!ok) begin
            checks++; failures++;
            $display("FAIL accept_timeout8 got in_ready=%b, required 1 within 200 cycles", in_ready8);
        end else begin
            exp8_q.push_back(e);
        end
        tick();
        in_valid8 = 1'b0;
    endtask

    // Accept an MDU op and check busy/in_ready across the whole latency.
    task automatic mdu32(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        send32(op, av, bv, 5'd0, 16'd0, model32(op, av, bv, 5'd0, 16'd0));
        for (int k = 0; k < W; k++) begin
            checks++;
            if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL mdu32_inflight step=%0d got busy=%b in_ready=%b out_valid=%b, required 1 0 0",
                         k, busy, in_ready, out_valid);
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL mdu32_latency got out_valid=%b busy=%b, required 1 0 after %0d edges",
                     out_valid, busy, W);
        end
    endtask

    task automatic mdu8(input logic [4:0] op, input logic [W8-1:0] av, input logic [W8-1:0] bv,
                        input logic [W8-1:0] e);
        send8(op, av, bv, 3'd0, 4'd0, e);
        for (int k = 0; k < W8; k++) begin
            checks++;
            if (busy8 !== 1'b1 || in_ready8 !== 1'b0 || out_valid8 !== 1'b0) begin
                failures++;
                $display("FAIL mdu8_inflight step=%0d got busy=%b in_ready=%b out_valid=%b, required 1 0 0",
                         k, busy8, in_ready8, out_valid8);
            end
            tick();
        end
        checks++;
        if (out_valid8 !== 1'b1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL mdu8_latency got out_valid=%b busy=%b, required 1 0 after %0d edges",
                     out_valid8, busy8, W8);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && (exp_q.size() != 0 || exp8_q.size() != 0); k++) tick();
        tick();
        checks++;
        if (exp_q.size() != 0 || exp8_q.size() != 0 || out_valid !== 1'b0 || out_valid8 !== 1'b0) begin
            failures++;
            $display("FAIL drain got pending32=%0d pending8=%0d out_valid=%b/%b, required 0 0 0/0",
                     exp_q.size(), exp8_q.size(), out_valid, out_valid8);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 0; out_ready = 1; a = 0; b = 0; f = 0; shamt = 0; imm = 0;
        in_valid8 = 0; out_ready8 = 1; a8 = 0; b8 = 0; f8 = 0; shamt8 = 0; imm8 = 0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || y !== '0 || zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_out got out_valid=%b Y=%h Zero=%b, required 0 0 1", out_valid, y, zero);
        end
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL reset_ctrl got in_ready=%b busy=%b state=%0d, required 1 0 0",
                     in_ready, busy, dbg_state);
        end
        checks++;
        if (out_valid8 !== 1'b0 || y8 !== '0 || zero8 !== 1'b1 || in_ready8 !== 1'b1 || busy8 !== 1'b0) begin
            failures++;
            $display("FAIL reset8 got out_valid=%b Y=%h Zero=%b in_ready=%b busy=%b, required 0 0 1 1 0",
                     out_valid8, y8, zero8, in_ready8, busy8);
        end
        tick();
    endtask

    task automatic test_reset_mid_div();
        bit seen;
        f = OP_DIVU; a = 100; b = 7; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL middiv_accept got in_ready=%b, required 1", in_ready);
        end
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (busy !== 1'b1 || dbg_state !== DIV) begin
            failures++;
            $display("FAIL middiv_busy got busy=%b state=%0d, required 1 2", busy, dbg_state);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || dbg_state !== IDLE) begin
            failures++;
            $display("FAIL middiv_abort got busy=%b out_valid=%b state=%0d, required 0 0 0",
                     busy, out_valid, dbg_state);
        end
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < W + 6; k++) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) seen = 1;
            tick();
        end
        checks++;
        if (seen) begin
            failures++;
            $display("FAIL middiv_noresult got a result or busy after abort, required none");
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        out_ready = 1'b1;
        c0 = cyc;
        send32(OP_ADD, 32'd7, 32'd5, 5'd0, 16'd0, 32'd12);
        send32(OP_SUB, 32'd5, 32'd5, 5'd0, 16'd0, 32'd0);
        send32(OP_SLT, 32'd1, 32'd2, 5'd0, 16'd0, 32'd1);
        send32(OP_SRA, 32'd0, 32'h8000_0000, 5'd4, 16'd0, 32'hF800_0000);
        send32(OP_LUI, 32'd0, 32'd0, 5'd0, 16'hABCD, 32'hABCD_0000);
        send32(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0, 16'd0, 32'h00F0_1234);
        send32(OP_OR,  32'hF000_0000, 32'h0000_000F, 5'd0, 16'd0, 32'hF000_000F);
        send32(OP_SLL, 32'd0, 32'h0000_0003, 5'd31, 16'd0, 32'h8000_0000);
        send32(OP_SRL, 32'd0, 32'h8000_0000, 5'd31, 16'd0, 32'h0000_0001);
        checks++;
        if (cyc - c0 !== 9) begin
            failures++;
            $display("FAIL throughput got %0d cycles for 9 ops, required 9", cyc - c0);
        end
        drain();
    endtask

    task automatic test_mdu();
        out_ready = 1'b1;
        mdu32(OP_MUL,  32'hFFFF_FFFF, 32'd2);
        mdu32(OP_MULH, 32'hFFFF_FFFF, 32'd2);
        mdu32(OP_DIVU, 32'd100, 32'd7);
        mdu32(OP_REMU, 32'd100, 32'd7);
        mdu32(OP_DIVU, 32'h1234_5678, 32'd0);
        mdu32(OP_REMU, 32'h1234_5678, 32'd0);
        mdu32(OP_MULH, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        mdu32(OP_DIVU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        send32(OP_ADD, 32'd10, 32'd20, 5'd0, 16'd0, 32'd30);
        f = OP_OR; a = 32'hF0; b = 32'h0F; in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || y !== 32'd30) begin
                failures++;
                $display("FAIL backpressure cycle=%0d got in_ready=%b out_valid=%b Y=%h, required 0 1 0000001e",
                         k, in_ready, out_valid, y);
            end
            tick();
        end
        out_ready = 1'b1;
        send32(OP_OR, 32'hF0, 32'h0F, 5'd0, 16'd0, 32'hFF);
        checks++;
        if (out_valid !== 1'b1 || y !== 32'hFF || exp_q.size() != 1) begin
            failures++;
            $display("FAIL consume_accept got out_valid=%b Y=%h pending=%0d, required 1 000000ff 1",
                     out_valid, y, exp_q.size());
        end
        drain();
    endtask

    task automatic test_random();
        logic [4:0]   op, sh;
        logic [W-1:0] av, bv;
        logic [15:0]  im;
        out_ready = 1'b1;
        for (int n = 0; n < 24; n++) begin
            op = 5'($urandom_range(0, 31));
            sh = 5'($urandom_range(0, 31));
            im = 16'($urandom_range(0, 65535));
            av = $urandom();
            bv = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom();
            send32(op, av, bv, sh, im, model32(op, av, bv, sh, im));
        end
        drain();
    endtask

    task automatic test_width8();
        out_ready8 = 1'b1;
        mdu8(OP_MUL,  8'd15,  8'd17, 8'hFF);
        mdu8(OP_DIVU, 8'd200, 8'd3,  8'd66);
        mdu8(OP_REMU, 8'd200, 8'd3,  8'd2);
        mdu8(OP_MULH, 8'd200, 8'd100, 8'd78);
        send8(OP_ADD, 8'd200, 8'd100, 3'd0, 4'd0, 8'd44);
        send8(OP_LUI, 8'd0, 8'd0, 3'd0, 4'hA, 8'hA0);
        send8(OP_SRA, 8'd0, 8'h80, 3'd7, 4'd0, 8'hFF);
        drain();
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        $display("FAIL watchdog simulation exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_reset_mid_div();
        test_back_to_back();
        test_mdu();
        test_backpressure();
        test_random();
        test_width8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
